// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi_slave_mem responder.
interface axi_slave_mem_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave with internal word memory, one transaction at a time.
// Optional AXI_SLV_RANGECHK_EN: out-of-span bursts get SLVERR, writes dropped, reads return 0.
//
// state  | meaning
// IDLE   | accept AW (priority) or AR
// WBEAT  | consume W beats until LEN+1 taken
// WRESP  | hold B response until BREADY
// RFETCH | synchronous memory read of current index
// RBEAT  | present R beat until RREADY
module axi_slave_mem #(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int MEM_DEPTH          = 256
) (
   input  logic             ACLK,
   input  logic             ARST,
   axi_slave_mem_if.slave   s_axi
);
   localparam int IW = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, WBEAT, WRESP, RFETCH, RBEAT} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic [7:0]    len;
   logic [7:0]    beat;
   logic          wlast_err;
   logic          rng_err;
   logic [1:0]    bresp_q;
   logic [31:0]   rdata_q;
   logic [31:0]   mem [MEM_DEPTH];

   logic aw_hs, ar_hs, w_hs, last_beat;
   logic aw_rng_err, ar_rng_err;
   logic unused_addr;

   assign aw_hs     = (state == IDLE) && !ARST && s_axi.awvalid;
   assign ar_hs     = (state == IDLE) && !ARST && !s_axi.awvalid && s_axi.arvalid;
   assign w_hs      = (state == WBEAT) && s_axi.wvalid;
   assign last_beat = (beat == len);
   assign unused_addr = ^{s_axi.awaddr, s_axi.araddr};

`ifdef AXI_SLV_RANGECHK_EN
   localparam logic [C_S_AXI_ADDR_WIDTH:0] SPAN = (C_S_AXI_ADDR_WIDTH+1)'(MEM_DEPTH * 4);
   assign aw_rng_err = ({1'b0, s_axi.awaddr} + (C_S_AXI_ADDR_WIDTH+1)'({s_axi.awlen, 2'b00})) >= SPAN;
   assign ar_rng_err = ({1'b0, s_axi.araddr} + (C_S_AXI_ADDR_WIDTH+1)'({s_axi.arlen, 2'b00})) >= SPAN;
`else
   assign aw_rng_err = 1'b0;
   assign ar_rng_err = 1'b0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      s_axi.awready = 1'b0;
      s_axi.arready = 1'b0;
      s_axi.wready  = 1'b0;
      s_axi.bvalid  = 1'b0;
      s_axi.rvalid  = 1'b0;
      case (state)
         IDLE: begin
            s_axi.awready = !ARST;
            s_axi.arready = !ARST && !s_axi.awvalid;
            if (aw_hs)      state_nxt = WBEAT;
            else if (ar_hs) state_nxt = RFETCH;
         end
         WBEAT: begin
            s_axi.wready = 1'b1;
            if (s_axi.wvalid && last_beat) state_nxt = WRESP;
         end
         WRESP: begin
            s_axi.bvalid = 1'b1;
            if (s_axi.bready) state_nxt = IDLE;
         end
         RFETCH: state_nxt = RBEAT;
         RBEAT: begin
            s_axi.rvalid = 1'b1;
            if (s_axi.rready) state_nxt = last_beat ? IDLE : RFETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign s_axi.bresp = bresp_q;
   assign s_axi.rresp = {(state == RBEAT) && rng_err, 1'b0};
   assign s_axi.rlast = (state == RBEAT) && last_beat;
   assign s_axi.rdata = rdata_q;

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         idx       <= '0;
         len       <= '0;
         beat      <= '0;
         wlast_err <= 1'b0;
         rng_err   <= 1'b0;
         bresp_q   <= 2'b00;
         rdata_q   <= '0;
      end else if (aw_hs) begin
         idx       <= s_axi.awaddr[IW+1:2];
         len       <= s_axi.awlen;
         beat      <= '0;
         wlast_err <= 1'b0;
         rng_err   <= aw_rng_err;
      end else if (ar_hs) begin
         idx       <= s_axi.araddr[IW+1:2];
         len       <= s_axi.arlen;
         beat      <= '0;
         rng_err   <= ar_rng_err;
      end else if (w_hs) begin
         idx  <= idx + 1'b1;
         beat <= beat + 1'b1;
         // a missing WLAST on the final beat or any earlier WLAST both flag SLVERR
         if (last_beat)
            bresp_q <= (rng_err || wlast_err || !s_axi.wlast) ? 2'b10 : 2'b00;
         else if (s_axi.wlast)
            wlast_err <= 1'b1;
      end else if (state == RFETCH) begin
         rdata_q <= rng_err ? '0 : mem[idx];
      end else if ((state == RBEAT) && s_axi.rready) begin
         idx  <= idx + 1'b1;
         beat <= beat + 1'b1;
      end
   end

   // memory has no reset; contents survive ARST
   always_ff @(posedge ACLK) begin
      if (w_hs && !ARST && !rng_err) begin
         for (int i = 0; i < 4; i++)
            if (s_axi.wstrb[i]) mem[idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (expectations follow AXI_SLV_RANGECHK_EN if defined).
module tb_axi_slave_mem;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_slave_mem_if #(.ADDR_WIDTH(32)) bus ();

   axi_slave_mem #(.C_S_AXI_ADDR_WIDTH(32), .MEM_DEPTH(256)) dut (
      .ACLK  (clk),
      .ARST  (rst),
      .s_axi (bus)
   );

`ifdef AXI_SLV_RANGECHK_EN
   localparam bit RCHK = 1'b1;
`else
   localparam bit RCHK = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_data [8];
   logic [1:0]  wr_resp;
   logic        wr_bnext;
   logic        wr_ok;
   logic [31:0] rd_data [8];
   logic        rd_last [8];
   logic [1:0]  rd_resp [8];
   int          rd_lat;
   logic        rd_ok;
   logic [31:0] exp_words [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] strb, input int wlast_beat);
      int n;
      wr_ok = 1'b1;
      bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < 50) begin tick(); n++; end
      if (!bus.awready) wr_ok = 1'b0;
      tick();
      bus.awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         bus.wdata = wr_data[b]; bus.wstrb = strb;
         bus.wlast = (b == wlast_beat); bus.wvalid = 1'b1;
         n = 0;
         while (!bus.wready && n < 50) begin tick(); n++; end
         if (!bus.wready) wr_ok = 1'b0;
         tick();
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      wr_bnext = bus.bvalid;
      bus.bready = 1'b1;
      n = 0;
      while (!bus.bvalid && n < 50) begin tick(); n++; end
      if (!bus.bvalid) wr_ok = 1'b0;
      wr_resp = bus.bresp;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len);
      int n;
      rd_ok = 1'b1;
      bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 50) begin tick(); n++; end
      if (!bus.arready) rd_ok = 1'b0;
      tick();
      bus.arvalid = 1'b0;
      rd_lat = 0;
      while (!bus.rvalid && rd_lat < 50) begin tick(); rd_lat++; end
      for (int b = 0; b <= int'(len); b++) begin
         bus.rready = 1'b1;
         n = 0;
         while (!bus.rvalid && n < 50) begin tick(); n++; end
         if (!bus.rvalid) rd_ok = 1'b0;
         rd_data[b] = bus.rdata; rd_last[b] = bus.rlast; rd_resp[b] = bus.rresp;
         tick();
      end
      bus.rready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.awvalid = 1'b1; bus.arvalid = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast});
      end
      checks++;
      if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {bus.bresp, bus.rresp, bus.rdata});
      end
      bus.awvalid = 1'b0; bus.arvalid = 1'b0; rst = 1'b0;
      #1;
      checks++;
      if ({bus.awready, bus.arready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 11", {bus.awready, bus.arready});
      end
      tick();
   endtask

   task automatic test_burst();
      exp_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int i = 0; i < 4; i++) wr_data[i] = exp_words[i];
      do_write(32'h10, 8'd3, 4'hF, 3);
      checks++;
      if ({wr_ok, wr_bnext, wr_resp} !== 4'b1100) begin
         errors++;
         $display("FAIL burst_bresp got ok/bnext/resp %b want 1100", {wr_ok, wr_bnext, wr_resp});
      end
      do_read(32'h10, 8'd3);
      checks++;
      if (rd_ok !== 1'b1 || rd_lat != 1) begin
         errors++;
         $display("FAIL burst_rlat got ok=%0b lat=%0d want ok=1 lat=1", rd_ok, rd_lat);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_data[i] !== exp_words[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
            errors++;
            $display("FAIL burst_beat%0d got %h last=%b resp=%b want %h last=%b resp=00",
                     i, rd_data[i], rd_last[i], rd_resp[i], exp_words[i], (i == 3));
         end
      end
   endtask

   task automatic test_strobe();
      wr_data[0] = 32'h12345678;
      do_write(32'h0, 8'd0, 4'hF, 0);
      wr_data[0] = 32'hAABBCCDD;
      do_write(32'h0, 8'd0, 4'b0011, 0);
      do_read(32'h0, 8'd0);
      checks++;
      if (rd_data[0] !== 32'h1234CCDD || rd_last[0] !== 1'b1) begin
         errors++;
         $display("FAIL strobe_merge got %h last=%b want 1234ccdd last=1", rd_data[0], rd_last[0]);
      end
   endtask

   task automatic test_stall();
      int n;
      bus.araddr = 32'h10; bus.arlen = 8'd3; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 50) begin tick(); n++; end
      tick();
      bus.arvalid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.rready = (b != 1);
         n = 0;
         while (!bus.rvalid && n < 50) begin tick(); n++; end
         if (b == 1) begin
            for (int c = 0; c < 5; c++) begin
               tick();
               checks++;
               if ({bus.rvalid, bus.rlast, bus.rdata} !== {1'b1, 1'b0, 32'h22222222}) begin
                  errors++;
                  $display("FAIL stall_hold cyc%0d got v=%b l=%b d=%h want v=1 l=0 d=22222222",
                           c, bus.rvalid, bus.rlast, bus.rdata);
               end
            end
            bus.rready = 1'b1;
         end
         checks++;
         if ({bus.rvalid, bus.rlast, bus.rdata} !== {1'b1, (b == 3), exp_words[b]}) begin
            errors++;
            $display("FAIL stall_beat%0d got v=%b l=%b d=%h want v=1 l=%b d=%h",
                     b, bus.rvalid, bus.rlast, bus.rdata, (b == 3), exp_words[b]);
         end
         tick();
      end
      bus.rready = 1'b0;
      checks++;
      if (bus.arready !== 1'b1) begin
         errors++;
         $display("FAIL stall_idle got arready=%b want 1", bus.arready);
      end
   endtask

   task automatic test_collision();
      bus.awaddr = 32'h80; bus.awlen = 8'd0; bus.awvalid = 1'b1;
      bus.araddr = 32'h80; bus.arlen = 8'd0; bus.arvalid = 1'b1;
      #1;
      checks++;
      if ({bus.awready, bus.arready} !== 2'b10) begin
         errors++;
         $display("FAIL coll_prio got aw/ar %b want 10", {bus.awready, bus.arready});
      end
      tick();
      bus.awvalid = 1'b0;
      bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      #1;
      checks++;
      if ({bus.wready, bus.arready} !== 2'b10) begin
         errors++;
         $display("FAIL coll_wbeat got wready/arready %b want 10", {bus.wready, bus.arready});
      end
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      checks++;
      if ({bus.bvalid, bus.arready, bus.bresp} !== 4'b1000) begin
         errors++;
         $display("FAIL coll_wresp got bvalid/arready/bresp %b want 1000",
                  {bus.bvalid, bus.arready, bus.bresp});
      end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      #1;
      checks++;
      if (bus.arready !== 1'b1) begin
         errors++;
         $display("FAIL coll_arready_after_b got %b want 1", bus.arready);
      end
      tick();
      bus.arvalid = 1'b0;
      tick();
      checks++;
      if ({bus.rvalid, bus.rlast, bus.rdata} !== {2'b11, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL coll_read got v=%b l=%b d=%h want v=1 l=1 d=cafef00d",
                  bus.rvalid, bus.rlast, bus.rdata);
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   task automatic test_wlast_err();
      wr_data[0] = 32'h00000001; wr_data[1] = 32'h00000002;
      do_write(32'h40, 8'd1, 4'hF, 0);
      checks++;
      if ({wr_ok, wr_resp} !== 3'b110) begin
         errors++;
         $display("FAIL wlast_early got ok/resp %b want 110", {wr_ok, wr_resp});
      end
      do_read(32'h40, 8'd1);
      checks++;
      if ({rd_data[0], rd_data[1]} !== {32'h1, 32'h2}) begin
         errors++;
         $display("FAIL wlast_consumed got %h %h want 00000001 00000002", rd_data[0], rd_data[1]);
      end
      wr_data[0] = 32'h00000003;
      do_write(32'h40, 8'd0, 4'hF, -1);
      checks++;
      if ({wr_ok, wr_resp} !== 3'b110) begin
         errors++;
         $display("FAIL wlast_missing got ok/resp %b want 110", {wr_ok, wr_resp});
      end
      do_write(32'h40, 8'd0, 4'hF, 0);
      checks++;
      if ({wr_ok, wr_resp} !== 3'b100) begin
         errors++;
         $display("FAIL wlast_ok got ok/resp %b want 100", {wr_ok, wr_resp});
      end
   endtask

   task automatic test_wrap();
      wr_data[0] = 32'hDEAD0001;
      do_write(32'h3FC, 8'd0, 4'hF, 0);
      wr_data[0] = 32'h5A5A0001; wr_data[1] = 32'h5A5A0002;
      do_write(32'h3FC, 8'd1, 4'hF, 1);
      checks++;
      if ({wr_ok, wr_resp} !== {1'b1, (RCHK ? 2'b10 : 2'b00)}) begin
         errors++;
         $display("FAIL wrap_bresp got ok/resp %b want 1%b", {wr_ok, wr_resp}, (RCHK ? 2'b10 : 2'b00));
      end
      do_read(32'h3FC, 8'd0);
      checks++;
      if (rd_data[0] !== (RCHK ? 32'hDEAD0001 : 32'h5A5A0001)) begin
         errors++;
         $display("FAIL wrap_top got %h want %h", rd_data[0], (RCHK ? 32'hDEAD0001 : 32'h5A5A0001));
      end
      do_read(32'h0, 8'd0);
      checks++;
      if (rd_data[0] !== (RCHK ? 32'h1234CCDD : 32'h5A5A0002)) begin
         errors++;
         $display("FAIL wrap_low got %h want %h", rd_data[0], (RCHK ? 32'h1234CCDD : 32'h5A5A0002));
      end
      do_read(32'h3FC, 8'd1);
      checks++;
      if ({rd_resp[1], rd_data[1]} !== (RCHK ? {2'b10, 32'h0} : {2'b00, 32'h5A5A0002})) begin
         errors++;
         $display("FAIL wrap_read got resp=%b d=%h want %h", rd_resp[1], rd_data[1],
                  (RCHK ? {2'b10, 32'h0} : {2'b00, 32'h5A5A0002}));
      end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      bus.araddr = 32'h10; bus.arlen = 8'd3; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 50) begin tick(); n++; end
      tick();
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      n = 0;
      while (!bus.rvalid && n < 50) begin tick(); n++; end
      tick();
      bus.rready = 1'b0;
      tick();
      checks++;
      if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h22222222}) begin
         errors++;
         $display("FAIL rstmid_beat2 got v=%b d=%h want v=1 d=22222222", bus.rvalid, bus.rdata);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.rvalid, bus.arready, bus.awready} !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_drop got rvalid/arready/awready %b want 000",
                  {bus.rvalid, bus.arready, bus.awready});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.arready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_arready got %b want 1", bus.arready);
      end
      do_read(32'h10, 8'd3);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rd_ok, rd_data[i], rd_last[i]} !== {1'b1, exp_words[i], (i == 3)}) begin
            errors++;
            $display("FAIL rstmid_reread%0d got ok=%b d=%h l=%b want ok=1 d=%h l=%b",
                     i, rd_ok, rd_data[i], rd_last[i], exp_words[i], (i == 3));
         end
      end
   endtask

   initial begin
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      test_reset();
      test_burst();
      test_strobe();
      test_stall();
      test_collision();
      test_wlast_err();
      test_wrap();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
